fir_sequencer: RTL

Parametrised control unit for the FIR datapath: it sequences an N-tap filter over the shared register file and ALU, loading coefficients, shifting the sample window, and running the multiply/accumulate chain. It sits between the host handshake (`dr`, `lc`) and the datapath: it drives `op`, `src1`, `src2` and `dest`, and watches `overflow`. Compared with the fixed 4-tap controller, it adds:
- tap count as a parameter;
- a per-tap add/subtract mask;
- counter-driven sequencing instead of unrolled states;
- a `coeff_ready` status flag;
- coefficient reload from the error state.

---
 rtl/fir_pkg.sv | 35 +++
 rtl/fir_sequencer_tap_counter.sv | 51 +++++
 rtl/fir_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencer.
// - op_e    : ALU op-codes driven onto the datapath.
// - state_e : sequencer FSM states.
// - is_busy : marks the states in which the sequencer reports busy (modwait).
package fir_pkg;

    typedef enum logic [2:0] {
        OpNop       = 3'b000,
        OpCopy      = 3'b001,
        OpLoad      = 3'b010,
        OpLoadCoeff = 3'b011,
        OpAdd       = 3'b100,
        OpSub       = 3'b101,
        OpMul       = 3'b110
    } op_e;

    typedef enum logic [3:0] {
        StIdle,
        StLoadC,
        StWaitC,
        StStore,
        StZero,
        StShift,
        StMul,
        StAcc,
        StCnt,
        StEidle
    } state_e;

    // Idle-like states (waiting on the host) are not busy; everything else is.
    function automatic logic is_busy(input state_e s);
        return !(s == StIdle || s == StWaitC || s == StEidle);
    endfunction

endpackage

// File: rtl/fir_sequencer_tap_counter.sv
// Tap index counter for the FIR sequencer.
// Ports:
//   clk_i, reset_i  : clock, asynchronous active-high reset
//   clr_i           : load zero (highest priority)
//   load_max_i      : load MaxVal
//   en_i, up_i      : count enable and direction (1 = up, 0 = down)
//   cnt_o           : current count
//   cnt_next_o      : value the count takes at the next edge
//   tc_o            : terminal count for the current direction
//                     (cnt == MaxVal when counting up, cnt == 0 when down)
module tap_counter #(
    parameter int unsigned Width  = 2,
    parameter int unsigned MaxVal = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             load_max_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [Width-1:0] cnt_o,
    output logic [Width-1:0] cnt_next_o,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_max_i) begin
            cnt_d = Width'(MaxVal);
        end else if (en_i) begin
            cnt_d = up_i ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign tc_o       = up_i ? (cnt_q == Width'(MaxVal)) : (cnt_q == '0);

endmodule

// File: rtl/fir_sequencer.sv
// FIR sequencer: control unit for an NTAPS-tap FIR over a shared register
// file and ALU. Loads coefficients, shifts the sample window and runs the
// multiply/accumulate chain, adding or subtracting each product per SUB_MASK.
// Register map: r0 acc, r1..rN coeffs, rN+1 sample, rN+2..r2N+1 window,
// r2N+2 product temporary.
// Ports:
//   clk_i, reset_i      : clock, asynchronous active-high reset
//   dr_i                : sample present on the datapath input
//   lc_i                : coefficient present on the datapath input
//   overflow_i          : ALU overflow for the current op
//   cnt_up_o            : one-cycle pulse when a sample completes
//   clear_o             : clears the sample counter (first coefficient load)
//   modwait_o           : busy flag
//   op_o                : ALU op-code
//   src1_o/src2_o/dest_o: register-file addresses
//   err_o               : high while in the error state
//   coeff_ready_o       : all coefficients loaded
// All outputs are registered; the decoded outputs are computed from the next
// state so they line up with the state they describe.
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned      NTAPS    = 4,
    parameter int unsigned      REG_AW   = 4,
    parameter logic [NTAPS-1:0] SUB_MASK = NTAPS'(4'b0101)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              dr_i,
    input  logic              lc_i,
    input  logic              overflow_i,
    output logic              cnt_up_o,
    output logic              clear_o,
    output logic              modwait_o,
    output logic [2:0]        op_o,
    output logic [REG_AW-1:0] src1_o,
    output logic [REG_AW-1:0] src2_o,
    output logic [REG_AW-1:0] dest_o,
    output logic              err_o,
    output logic              coeff_ready_o
);

    localparam int unsigned IdxW       = $clog2(NTAPS);
    localparam int unsigned CoeffBase  = 1;
    localparam int unsigned SampleAddr = NTAPS + 1;
    localparam int unsigned WinBase    = NTAPS + 2;
    localparam int unsigned TmpAddr    = 2 * NTAPS + 2;

    function automatic logic [REG_AW-1:0] reg_addr(input int unsigned base,
                                                   input logic [IdxW-1:0] i);
        return REG_AW'(base + 32'(i));
    endfunction

    state_e            state_q, state_d;
    logic              coeff_ready_q, coeff_ready_d;
    logic              modwait_q;
    op_e               op_q, op_d;
    logic [REG_AW-1:0] src1_q, src1_d, src2_q, src2_d, dest_q, dest_d;
    logic              clear_q, clear_d, cnt_up_q, cnt_up_d, err_q, err_d;

    logic [IdxW-1:0]   idx_q, idx_d;
    logic              idx_tc, idx_clr, idx_ld_max, idx_en, idx_up;

    tap_counter #(
        .Width  (IdxW),
        .MaxVal (NTAPS - 1)
    ) u_tap_counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (idx_clr),
        .load_max_i (idx_ld_max),
        .en_i       (idx_en),
        .up_i       (idx_up),
        .cnt_o      (idx_q),
        .cnt_next_o (idx_d),
        .tc_o       (idx_tc)
    );

    // Next state, tap index control and coefficient status.
    always_comb begin
        state_d       = state_q;
        coeff_ready_d = coeff_ready_q;
        idx_clr       = 1'b0;
        idx_ld_max    = 1'b0;
        idx_en        = 1'b0;
        idx_up        = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (lc_i) begin
                    state_d = StLoadC;
                    idx_clr = 1'b1;
                end else if (dr_i) begin
                    state_d = coeff_ready_q ? StStore : StEidle;
                end
            end
            StLoadC: begin
                // A fresh load sequence invalidates the previous coefficient set.
                if (idx_q == '0) coeff_ready_d = 1'b0;
                if (idx_tc) begin
                    coeff_ready_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    idx_en  = 1'b1;
                    state_d = StWaitC;
                end
            end
            StWaitC: begin
                if (lc_i) state_d = StLoadC;
            end
            StStore: begin
                state_d = dr_i ? StZero : StEidle;
            end
            StZero: begin
                state_d    = StShift;
                idx_ld_max = 1'b1;
            end
            StShift: begin
                // Walk from the oldest tap down so no tap is overwritten early.
                idx_up = 1'b0;
                if (idx_tc) begin
                    state_d = StMul;
                end else begin
                    idx_en = 1'b1;
                end
            end
            StMul: begin
                state_d = StAcc;
            end
            StAcc: begin
                if (overflow_i) begin
                    state_d = StEidle;
                end else if (idx_tc) begin
                    state_d = StCnt;
                end else begin
                    idx_en  = 1'b1;
                    state_d = StMul;
                end
            end
            StCnt: begin
                state_d = StIdle;
            end
            StEidle: begin
                if (lc_i) begin
                    state_d = StLoadC;
                    idx_clr = 1'b1;
                end else if (dr_i && coeff_ready_q) begin
                    state_d = StStore;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode for the state being entered.
    always_comb begin
        op_d     = OpNop;
        src1_d   = '0;
        src2_d   = '0;
        dest_d   = '0;
        clear_d  = 1'b0;
        cnt_up_d = 1'b0;
        err_d    = 1'b0;
        unique case (state_d)
            StLoadC: begin
                op_d    = OpLoadCoeff;
                dest_d  = reg_addr(CoeffBase, idx_d);
                clear_d = (idx_d == '0);
            end
            StStore: begin
                op_d   = OpLoad;
                dest_d = REG_AW'(SampleAddr);
            end
            StZero: begin
                op_d = OpSub;
            end
            StShift: begin
                op_d   = OpCopy;
                dest_d = reg_addr(WinBase, idx_d);
                src1_d = reg_addr(SampleAddr, idx_d);
            end
            StMul: begin
                op_d   = OpMul;
                src1_d = reg_addr(CoeffBase, idx_d);
                src2_d = reg_addr(WinBase, idx_d);
                dest_d = REG_AW'(TmpAddr);
            end
            StAcc: begin
                op_d   = SUB_MASK[idx_d] ? OpSub : OpAdd;
                src2_d = REG_AW'(TmpAddr);
            end
            StCnt: begin
                cnt_up_d = 1'b1;
            end
            StEidle: begin
                err_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            coeff_ready_q <= 1'b0;
            modwait_q     <= 1'b0;
            op_q          <= OpNop;
            src1_q        <= '0;
            src2_q        <= '0;
            dest_q        <= '0;
            clear_q       <= 1'b0;
            cnt_up_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            coeff_ready_q <= coeff_ready_d;
            modwait_q     <= is_busy(state_d);
            op_q          <= op_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            dest_q        <= dest_d;
            clear_q       <= clear_d;
            cnt_up_q      <= cnt_up_d;
            err_q         <= err_d;
        end
    end

    assign op_o          = op_q;
    assign src1_o        = src1_q;
    assign src2_o        = src2_q;
    assign dest_o        = dest_q;
    assign clear_o       = clear_q;
    assign cnt_up_o      = cnt_up_q;
    assign err_o         = err_q;
    assign modwait_o     = modwait_q;
    assign coeff_ready_o = coeff_ready_q;

endmodule
